// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic {
        WB_SRC_ID  = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Circular deferral buffer for ID-stage writes, with squash-by-address and per-entry taps.
module wb_skid_fifo import wb_pkg::*; #(
    parameter int  SKID_DEPTH = 2,
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1),
    localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              squash,
    input  logic [ADDR_W-1:0] squash_addr,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic [PTR_W-1:0]  head_ptr,
    output wb_entry_t         entries [SKID_DEPTH]
);

    wb_entry_t        mem [SKID_DEPTH];
    logic [PTR_W-1:0] tail_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == CNT_W'(SKID_DEPTH));

    always_comb begin
        for (int i = 0; i < SKID_DEPTH; i++) begin
            entries[i] = mem[i];
        end
    end

    // Squash first, then push: an entry written this edge is younger than the ALU write and survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (squash && (mem[i].addr == squash_addr)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[head_ptr].valid <= 1'b0;
                head_ptr            <= ptr_inc(head_ptr);
            end
            if (push) begin
                mem[tail_ptr] <= push_entry;
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file writer: ALU/ID arbitration, ID deferral, registered write port, pending-write scoreboard.
// Optional forwarding outputs fwd_valid1/2, fwd_data1/2 are built when WB_FWD_EN is defined.
module reg_writeback_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_addr,
    input  logic [DATA_W-1:0] id_data,
    output logic              id_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_value_alu,
    output logic [DATA_W-1:0] write_value_id,
    output logic              write_data_sel,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [7:0]        pend_mask
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_valid2,
    output logic [DATA_W-1:0] fwd_data2
`endif
);
    import wb_pkg::*;

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic             run;
    logic             alu_acc, id_acc, id_direct;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] head_ptr;
    wb_entry_t        push_entry, head_entry;
    wb_entry_t        entries [SKID_DEPTH];

    wb_skid_fifo #(.SKID_DEPTH(SKID_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .squash      (alu_acc),
        .squash_addr (alu_addr),
        .count       (fifo_count),
        .full        (fifo_full),
        .head_ptr    (head_ptr),
        .entries     (entries)
    );

    // run gates both readies low while reset is held and for the release edge.
    assign alu_ready  = run;
    assign id_ready   = run && !fifo_full;
    assign alu_acc    = alu_valid && run;
    assign id_acc     = id_valid && id_ready;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = !alu_acc && !fifo_empty;
    assign id_direct  = !alu_acc && fifo_empty && id_acc;
    assign fifo_push  = id_acc && !id_direct;
    assign push_entry = '{valid: 1'b1, addr: id_addr, data: id_data};
    assign head_entry = entries[head_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run             <= 1'b0;
            write_enable    <= 1'b0;
            write_addr      <= '0;
            write_value_alu <= '0;
            write_value_id  <= '0;
            write_data_sel  <= WB_SRC_ID;
        end else begin
            run             <= 1'b1;
            write_enable    <= 1'b0;
            write_addr      <= '0;
            write_value_alu <= '0;
            write_value_id  <= '0;
            write_data_sel  <= WB_SRC_ID;
            if (alu_acc) begin
                write_enable    <= 1'b1;
                write_addr      <= alu_addr;
                write_value_alu <= alu_data;
                write_data_sel  <= WB_SRC_ALU;
            end else if (fifo_pop) begin
                // A squashed head still consumes its slot, leaving a bubble.
                if (head_entry.valid) begin
                    write_enable   <= 1'b1;
                    write_addr     <= head_entry.addr;
                    write_value_id <= head_entry.data;
                end
            end else if (id_direct) begin
                write_enable   <= 1'b1;
                write_addr     <= id_addr;
                write_value_id <= id_data;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < SKID_DEPTH; i++) begin
            if (entries[i].valid) begin
                pend_mask[entries[i].addr] = 1'b1;
            end
        end
        if (write_enable) begin
            pend_mask[write_addr] = 1'b1;
        end
    end

    assign hazard1 = pend_mask[rd_addr1];
    assign hazard2 = pend_mask[rd_addr2];

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match left standing is the youngest pending value.
    always_comb begin
        logic [DATA_W-1:0] out_val;
        int                idx;
        out_val    = write_data_sel ? write_value_alu : write_value_id;
        fwd_valid1 = write_enable && (write_addr == rd_addr1);
        fwd_data1  = fwd_valid1 ? out_val : '0;
        fwd_valid2 = write_enable && (write_addr == rd_addr2);
        fwd_data2  = fwd_valid2 ? out_val : '0;
        for (int k = 0; k < SKID_DEPTH; k++) begin
            idx = int'(head_ptr) + k;
            if (idx >= SKID_DEPTH) begin
                idx = idx - SKID_DEPTH;
            end
            if (entries[idx].valid && (entries[idx].addr == rd_addr1)) begin
                fwd_valid1 = 1'b1;
                fwd_data1  = entries[idx].data;
            end
            if (entries[idx].valid && (entries[idx].addr == rd_addr2)) begin
                fwd_valid2 = 1'b1;
                fwd_data2  = entries[idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: directed writes queue expectations, a monitor checks each write.
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, id_valid;
    logic [2:0]  alu_addr, id_addr, rd_addr1, rd_addr2;
    logic [31:0] alu_data, id_data;
    logic        alu_ready, id_ready, write_enable, write_data_sel, hazard1, hazard2;
    logic [2:0]  write_addr;
    logic [31:0] write_value_alu, write_value_id;
    logic [7:0]  pend_mask;
`ifdef WB_FWD_EN
    logic        fwd_valid1, fwd_valid2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic        sel;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_writeback_ctrl dut (
        .clk             (clk),
        .reset           (rst_n),
        .alu_valid       (alu_valid),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .id_valid        (id_valid),
        .id_addr         (id_addr),
        .id_data         (id_data),
        .id_ready        (id_ready),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_value_alu (write_value_alu),
        .write_value_id  (write_value_id),
        .write_data_sel  (write_data_sel),
        .rd_addr1        (rd_addr1),
        .rd_addr2        (rd_addr2),
        .hazard1         (hazard1),
        .hazard2         (hazard2),
        .pend_mask       (pend_mask)
`ifdef WB_FWD_EN
        ,
        .fwd_valid1      (fwd_valid1),
        .fwd_data1       (fwd_data1),
        .fwd_valid2      (fwd_valid2),
        .fwd_data2       (fwd_data2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [2:0] a, input logic s, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.sel  = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_alu(input logic v, input logic [2:0] a, input logic [31:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic set_id(input logic v, input logic [2:0] a, input logic [31:0] d);
        id_valid = v;
        id_addr  = a;
        id_data  = d;
    endtask

    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d alu 0x%0h id 0x%0h, expected no write",
                         write_addr, write_value_alu, write_value_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(write_addr), 32'(e.addr));
                chk("write_data_sel", 32'(write_data_sel), 32'(e.sel));
                chk("write_value_alu", write_value_alu, e.sel ? e.data : 32'h0);
                chk("write_value_id", write_value_id, e.sel ? 32'h0 : e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        set_alu(0, 0, 0);
        set_id(0, 0, 0);
        rd_addr1 = 0;
        rd_addr2 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_write_enable", 32'(write_enable), 0);
        chk("rst_pend_mask", 32'(pend_mask), 0);
        chk("rst_id_ready", 32'(id_ready), 0);
        chk("rst_alu_ready", 32'(alu_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rel_id_ready", 32'(id_ready), 1);
        chk("rel_alu_ready", 32'(alu_ready), 1);

        // Single ALU write
        set_alu(1, 3, 32'hDEADBEEF);
        expect_wr(3, 1, 32'hDEADBEEF);
        step();
        chk("alu_pend_mask", 32'(pend_mask), 32'h08);
        set_alu(0, 0, 0);
        step();
        chk("alu_pend_clear", 32'(pend_mask), 0);

        // ALU and ID together: ALU first, ID deferred one slot
        set_alu(1, 1, 32'h11);
        set_id(1, 2, 32'h22);
        expect_wr(1, 1, 32'h11);
        expect_wr(2, 0, 32'h22);
        step();
        chk("dual_pend_1", 32'(pend_mask), 32'h06);
        set_alu(0, 0, 0);
        set_id(0, 0, 0);
        step();
        chk("dual_pend_2", 32'(pend_mask), 32'h04);
        step();
        chk("dual_pend_3", 32'(pend_mask), 0);

        // Reset mid-stream with a write in the output stage and one queued
        set_alu(1, 6, 32'h66);
        set_id(1, 7, 32'h77);
        step();
        chk("mid_pend_mask", 32'(pend_mask), 32'hC0);
        #1 rst_n = 1'b0;
        set_alu(0, 0, 0);
        set_id(0, 0, 0);
        #1;
        chk("mid_rst_write_enable", 32'(write_enable), 0);
        chk("mid_rst_pend_mask", 32'(pend_mask), 0);
        chk("mid_rst_id_ready", 32'(id_ready), 0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        step();
        chk("mid_rel_id_ready", 32'(id_ready), 1);
        chk("mid_rel_pend_mask", 32'(pend_mask), 0);

        // Squash: queued ID r5=0xA is overtaken by ALU r5=0xB
        set_alu(1, 0, 32'h100);
        set_id(1, 5, 32'hA);
        expect_wr(0, 1, 32'h100);
        step();
        set_id(0, 0, 0);
        set_alu(1, 1, 32'h101);
        expect_wr(1, 1, 32'h101);
        step();
        rd_addr1 = 5;
        #1;
        chk("sq_hazard1", 32'(hazard1), 1);
        chk("sq_pend_mask_q", 32'(pend_mask), 32'h22);
        set_alu(1, 2, 32'h102);
        expect_wr(2, 1, 32'h102);
        step();
        set_alu(1, 5, 32'hB);
        expect_wr(5, 1, 32'hB);
        step();
        chk("sq_pend_mask_alu", 32'(pend_mask), 32'h20);
        set_alu(0, 0, 0);
        step();
        chk("sq_bubble_we", 32'(write_enable), 0);
        chk("sq_bubble_pend", 32'(pend_mask), 0);
        chk("sq_hazard1_clear", 32'(hazard1), 0);
        step();

        // Full: ALU busy every cycle, ID offered three times
        set_alu(1, 0, 32'h200);
        set_id(1, 3, 32'h31);
        expect_wr(0, 1, 32'h200);
        chk("full_ready_c0", 32'(id_ready), 1);
        step();
        set_alu(1, 1, 32'h201);
        set_id(1, 4, 32'h32);
        expect_wr(1, 1, 32'h201);
        chk("full_ready_c1", 32'(id_ready), 1);
        step();
        set_alu(1, 2, 32'h202);
        set_id(1, 6, 32'h33);
        expect_wr(2, 1, 32'h202);
        chk("full_ready_c2", 32'(id_ready), 0);
        step();
        chk("full_pend_mask", 32'(pend_mask), 32'h1C);
        set_alu(0, 0, 0);
        expect_wr(3, 0, 32'h31);
        chk("full_ready_c3", 32'(id_ready), 0);
        step();
        expect_wr(4, 0, 32'h32);
        expect_wr(6, 0, 32'h33);
        chk("full_ready_c4", 32'(id_ready), 1);
        step();
        set_id(0, 0, 0);
        step();
        step();
        step();

        // Two queued writes to r4: youngest value wins for forwarding
        set_alu(1, 0, 32'h300);
        set_id(1, 4, 32'h1);
        expect_wr(0, 1, 32'h300);
        step();
        set_alu(1, 1, 32'h301);
        set_id(1, 4, 32'h2);
        expect_wr(1, 1, 32'h301);
        expect_wr(4, 0, 32'h1);
        expect_wr(4, 0, 32'h2);
        step();
        set_alu(0, 0, 0);
        set_id(0, 0, 0);
        rd_addr1 = 4;
        rd_addr2 = 1;
        #1;
        chk("fwd_hazard1", 32'(hazard1), 1);
        chk("fwd_hazard2", 32'(hazard2), 1);
        chk("fwd_pend_mask", 32'(pend_mask), 32'h12);
`ifdef WB_FWD_EN
        chk("fwd_valid1", 32'(fwd_valid1), 1);
        chk("fwd_data1", fwd_data1, 32'h2);
        chk("fwd_valid2", 32'(fwd_valid2), 1);
        chk("fwd_data2", fwd_data2, 32'h301);
`endif
        rd_addr2 = 7;
        #1;
        chk("nohaz_hazard2", 32'(hazard2), 0);
`ifdef WB_FWD_EN
        chk("nofwd_valid2", 32'(fwd_valid2), 0);
`endif
        step();
        step();
        step();
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
